// File: rtl/rx_q_ptr_mem_if.sv
// Pointer-store channel bundle: valid/ready read request/response plus a write port.
// The responder (pointer store) uses the slave modport, the requester uses master.
interface rx_q_ptr_mem_if #(
    parameter int unsigned FLOW_ID_W = 8,
    parameter int unsigned PTR_W     = 10
);
    logic                 rd_req_val;
    logic [FLOW_ID_W-1:0] rd_req_addr;
    logic                 rd_req_rdy;
    logic                 rd_resp_val;
    logic [PTR_W-1:0]     rd_resp_data;
    logic                 rd_resp_rdy;
    logic                 wr_req_val;
    logic [FLOW_ID_W-1:0] wr_req_addr;
    logic [PTR_W-1:0]     wr_req_data;
    logic                 wr_req_rdy;
    logic                 init_done;

    modport slave (
        input  rd_req_val, rd_req_addr, rd_resp_rdy, wr_req_val, wr_req_addr, wr_req_data,
        output rd_req_rdy, rd_resp_val, rd_resp_data, wr_req_rdy, init_done
    );

    modport master (
        output rd_req_val, rd_req_addr, rd_resp_rdy, wr_req_val, wr_req_addr, wr_req_data,
        input  rd_req_rdy, rd_resp_val, rd_resp_data, wr_req_rdy, init_done
    );
endinterface

// File: rtl/rx_q_ptr_mem.sv
// Per-flow RX payload queue pointer store (head or tail). Clears all entries after reset,
// then serves a 1-cycle-latency registered read channel and an always-ready write port.
module rx_q_ptr_mem #(
    parameter int unsigned FLOW_ID_W = 8,
    parameter int unsigned PTR_W     = 10
) (
    input logic                  clk,
    input logic                  rst,
    rx_q_ptr_mem_if.slave        bus
);
    localparam int unsigned Depth = 2 ** FLOW_ID_W;

    typedef enum logic {StInit, StRun} state_e;

    state_e               state_q, state_d;
    logic [FLOW_ID_W-1:0] init_cnt_q, init_cnt_d;
    logic                 resp_val_q, resp_val_d;
    logic [PTR_W-1:0]     resp_data_q, resp_data_d;
    logic [PTR_W-1:0]     mem_q [Depth];

    logic                 run;
    logic                 rd_fire, wr_fire;
    logic                 mem_we;
    logic [FLOW_ID_W-1:0] mem_waddr;
    logic [PTR_W-1:0]     mem_wdata;
    logic [PTR_W-1:0]     rd_data;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        run        = 1'b0;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == FLOW_ID_W'(Depth - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: run = 1'b1;
            default: state_d = StInit;
        endcase
    end

    assign bus.rd_req_rdy   = run & (~resp_val_q | bus.rd_resp_rdy);
    assign bus.wr_req_rdy   = run;
    assign bus.init_done    = run;
    assign bus.rd_resp_val  = resp_val_q;
    assign bus.rd_resp_data = resp_data_q;

    assign rd_fire = bus.rd_req_val & bus.rd_req_rdy;
    assign wr_fire = bus.wr_req_val & bus.wr_req_rdy;

    // The init sweep and the write port share the single memory write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_req_addr;
        mem_wdata = bus.wr_req_data;
        if (!rst) begin
            if (state_q == StInit) begin
                mem_we    = 1'b1;
                mem_waddr = init_cnt_q;
                mem_wdata = '0;
            end else if (wr_fire) begin
                mem_we = 1'b1;
            end
        end
    end

    // Write-first forwarding for a same-cycle write to the address being read.
    always_comb begin
        rd_data = mem_q[bus.rd_req_addr];
        if (wr_fire && (bus.wr_req_addr == bus.rd_req_addr)) begin
            rd_data = bus.wr_req_data;
        end
    end

    always_comb begin
        resp_val_d  = resp_val_q;
        resp_data_d = resp_data_q;
        if (rd_fire) begin
            resp_val_d  = 1'b1;
            resp_data_d = rd_data;
        end else if (bus.rd_resp_rdy) begin
            resp_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            resp_val_q  <= 1'b0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            resp_val_q  <= resp_val_d;
            resp_data_q <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_rx_q_ptr_mem.sv
// Bench for rx_q_ptr_mem: directed scenarios plus random traffic, each cycle compared
// against a flat-array pointer store model with an expected-response slot.
module tb_rx_q_ptr_mem;
    localparam int unsigned FlowIdW = 8;
    localparam int unsigned PtrW    = 10;
    localparam int unsigned Depth   = 2 ** FlowIdW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_q_ptr_mem_if #(.FLOW_ID_W(FlowIdW), .PTR_W(PtrW)) bus ();

    rx_q_ptr_mem #(.FLOW_ID_W(FlowIdW), .PTR_W(PtrW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [PtrW-1:0] mdl_mem [Depth];
    int              init_left  = 0;
    bit              pend_valid = 1'b0;
    logic [PtrW-1:0] pend_data  = '0;
    bit              chk_en     = 1'b0;
    bit              just_reset = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model by one edge.
    task automatic step();
        bit in_run, exp_rdy;
        @(negedge clk);
        in_run  = (init_left == 0);
        exp_rdy = in_run && (!pend_valid || bus.rd_resp_rdy);
        if (chk_en) begin
            check_eq("rd_req_rdy", 32'(bus.rd_req_rdy), 32'(exp_rdy));
            check_eq("wr_req_rdy", 32'(bus.wr_req_rdy), 32'(in_run));
            check_eq("init_done", 32'(bus.init_done), 32'(in_run));
            check_eq("rd_resp_val", 32'(bus.rd_resp_val), 32'(pend_valid));
            if (pend_valid || just_reset) begin
                check_eq("rd_resp_data", 32'(bus.rd_resp_data), 32'(pend_data));
            end
        end
        just_reset = 1'b0;
        if (rst) begin
            init_left  = Depth;
            pend_valid = 1'b0;
            pend_data  = '0;
            just_reset = 1'b1;
            for (int i = 0; i < Depth; i++) mdl_mem[i] = '0;
        end else if (!in_run) begin
            init_left--;
        end else begin
            if (bus.wr_req_val) mdl_mem[bus.wr_req_addr] = bus.wr_req_data;
            if (bus.rd_req_val && exp_rdy) begin
                pend_valid = 1'b1;
                pend_data  = mdl_mem[bus.rd_req_addr];
            end else if (bus.rd_resp_rdy) begin
                pend_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_req_val  = 1'b0;
        bus.rd_req_addr = '0;
        bus.rd_resp_rdy = 1'b1;
        bus.wr_req_val  = 1'b0;
        bus.wr_req_addr = '0;
        bus.wr_req_data = '0;
    endtask

    task automatic do_write(input int a, input int d);
        bus.wr_req_val  = 1'b1;
        bus.wr_req_addr = FlowIdW'(a);
        bus.wr_req_data = PtrW'(d);
        step();
        bus.wr_req_val  = 1'b0;
    endtask

    // Reset for one cycle, then count cycles until init_done, bounded.
    task automatic reset_and_init(input string tag);
        int n;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        rst = 1'b0;
        n = 0;
        while (bus.init_done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check_eq(tag, 32'(n), 32'(Depth));
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;

        // T1: init, with a write attempted (and ignored) and a read stalled throughout.
        bus.wr_req_val  = 1'b1;
        bus.wr_req_addr = 8'd5;
        bus.wr_req_data = 10'h3ff;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 8'd5;
        reset_and_init("init_len");
        bus.wr_req_val = 1'b0;
        for (int a = 0; a < Depth; a++) begin
            bus.rd_req_val  = 1'b1;
            bus.rd_req_addr = FlowIdW'(a);
            step();
        end
        idle_inputs();
        step();

        // T2: write then read.
        do_write(3, 10'h205);
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 8'd3;
        step();
        bus.rd_req_val = 1'b0;
        check_eq("t2_data", 32'(bus.rd_resp_data), 32'h205);
        step();

        // T3: same-cycle write/read, then a later write must not disturb the held response.
        bus.rd_resp_rdy = 1'b0;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 8'd7;
        do_write(7, 10'h011);
        bus.rd_req_val = 1'b0;
        do_write(7, 10'h022);
        step();
        check_eq("t3_held", 32'(bus.rd_resp_data), 32'h011);
        bus.rd_resp_rdy = 1'b1;
        step();

        // T4: back-pressure with a request held on flow 2.
        do_write(1, 10'h001);
        do_write(2, 10'h2aa);
        bus.rd_resp_rdy = 1'b0;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 8'd1;
        step();
        bus.rd_req_addr = 8'd2;
        for (int i = 0; i < 5; i++) step();
        bus.rd_resp_rdy = 1'b1;
        step();
        bus.rd_req_val = 1'b0;
        check_eq("t4_next", 32'(bus.rd_resp_data), 32'h2aa);
        step();

        // T5: streaming reads of flows 0..15 after loading distinct values.
        for (int a = 0; a < 16; a++) do_write(a, 10'h200 + a * 3);
        for (int a = 0; a < 16; a++) begin
            bus.rd_req_val  = 1'b1;
            bus.rd_req_addr = FlowIdW'(a);
            step();
        end
        bus.rd_req_val = 1'b0;
        step();

        // Random traffic, biased toward a few flows to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            bus.rd_req_val  = ($urandom_range(0, 3) != 0);
            bus.rd_req_addr = ($urandom_range(0, 1) != 0) ? FlowIdW'($urandom_range(0, 3))
                                                          : FlowIdW'($urandom);
            bus.rd_resp_rdy = ($urandom_range(0, 9) < 7);
            bus.wr_req_val  = ($urandom_range(0, 1) != 0);
            bus.wr_req_addr = ($urandom_range(0, 1) != 0) ? FlowIdW'($urandom_range(0, 3))
                                                          : FlowIdW'($urandom);
            bus.wr_req_data = PtrW'($urandom);
            step();
        end
        idle_inputs();
        step();

        // T6: reset while a response is stalled, then previously written flows read 0.
        do_write(9, 10'h3c3);
        bus.rd_resp_rdy = 1'b0;
        bus.rd_req_val  = 1'b1;
        bus.rd_req_addr = 8'd9;
        step();
        bus.rd_req_val = 1'b0;
        step();
        reset_and_init("t6_init_len");
        bus.rd_resp_rdy = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.rd_req_val  = 1'b1;
            bus.rd_req_addr = FlowIdW'(a);
            step();
        end
        bus.rd_req_val = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end
endmodule
